// File: rtl/nic_pkg.sv
// Shared constants for the NIC channel interface: register map, widths and
// drop-counter width.
package nic_pkg;

    localparam int NIC_DATA_WIDTH = 64;
    localparam int NIC_ADDR_WIDTH = 2;
    localparam int NIC_DROP_CNT_W = 8;

    localparam logic [1:0] NIC_ADDR_IN_BUF  = 2'b00;
    localparam logic [1:0] NIC_ADDR_IN_STS  = 2'b01;
    localparam logic [1:0] NIC_ADDR_OUT_BUF = 2'b10;
    localparam logic [1:0] NIC_ADDR_OUT_STS = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry channel buffer with a full flag; a load is only taken while
// the entry is empty, a consume only frees a full entry.
module nic_chan_buf
    import nic_pkg::*;
#(
    parameter int DATA_WIDTH = NIC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  consume,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            data <= '0;
            full <= 1'b0;
        end else if (load && !full) begin
            data <= load_data;
            full <= 1'b1;
        end else if (consume && full) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/nic_channel_if.sv
// NIC between the 3-stage pipeline and the router: one ingress and one egress
// single-entry buffer. Optional macro NIC_DROP_CNT_EN adds a dropped-write counter.
module nic_channel_if
    import nic_pkg::*;
#(
    parameter int DATA_WIDTH = NIC_DATA_WIDTH,
    parameter int ADDR_WIDTH = NIC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic [ADDR_WIDTH-1:0] addr_nic,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do
);

    function automatic logic [DATA_WIDTH-1:0] sts_word(
        input logic [NIC_DROP_CNT_W-1:0] cnt,
        input logic                      flag
    );
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        w[0] = flag;
        w[8 +: NIC_DROP_CNT_W] = cnt;
        return w;
    endfunction

    logic                      rd_en;
    logic                      wr_en;
    logic                      rd_in_buf;
    logic                      rd_out_sts;
    logic                      wr_out_buf;
    logic                      drain;
    logic                      in_full;
    logic                      out_full;
    logic [DATA_WIDTH-1:0]     in_buf;
    logic [DATA_WIDTH-1:0]     out_buf;
    logic [DATA_WIDTH-1:0]     rd_data_p0;
    logic [NIC_DROP_CNT_W-1:0] drop_cnt;

    assign rd_en      = nicEn & ~nicEnWr;
    assign wr_en      = nicEn & nicEnWr;
    assign rd_in_buf  = rd_en && (addr_nic == NIC_ADDR_IN_BUF);
    assign rd_out_sts = rd_en && (addr_nic == NIC_ADDR_OUT_STS);
    assign wr_out_buf = wr_en && (addr_nic == NIC_ADDR_OUT_BUF);
    assign drain      = out_full & net_ro;
    assign net_ri     = ~in_full;

    // Ingress: router offers are taken only while the entry is empty (net_ri).
    nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (net_si),
        .consume   (rd_in_buf),
        .load_data (net_di),
        .data      (in_buf),
        .full      (in_full)
    );

    // Egress: a write against a full entry is dropped, even if it drains this edge.
    nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (wr_out_buf),
        .consume   (drain),
        .load_data (d_in),
        .data      (out_buf),
        .full      (out_full)
    );

`ifdef NIC_DROP_CNT_EN
    function automatic logic [NIC_DROP_CNT_W-1:0] sat_inc(
        input logic [NIC_DROP_CNT_W-1:0] c
    );
        return (&c) ? c : c + NIC_DROP_CNT_W'(1);
    endfunction

    logic drop;
    assign drop = wr_out_buf & out_full;

    // A status read clears the count; a drop at the same edge restarts it at one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (rd_out_sts) begin
            drop_cnt <= NIC_DROP_CNT_W'(drop);
        end else if (drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end
`else
    assign drop_cnt = '0;
`endif

    always_comb begin
        rd_data_p0 = '0;
        case (addr_nic)
            NIC_ADDR_IN_BUF:  rd_data_p0 = in_buf;
            NIC_ADDR_IN_STS:  rd_data_p0 = sts_word('0, in_full);
            NIC_ADDR_OUT_STS: rd_data_p0 = sts_word(drop_cnt, out_full);
            default:          rd_data_p0 = '0;
        endcase
    end

    // ---- stage 3 boundary: read data registered for the result mux ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rd_data_p0;
        end
    end

    // ---- router egress register: one-cycle net_so pulse per packet ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            net_so <= 1'b0;
            net_do <= '0;
        end else begin
            net_so <= drain;
            if (drain) begin
                net_do <= out_buf;
            end
        end
    end

endmodule
